// File: rtl/lsu_ctrl_if.sv
// ----------------------------------------------------------------------------
// lsu_ctrl_if
//
// Bundles every handshake and bus signal of the load/store unit: the request
// channel from the execute stage, the one-cycle response, and the port pair
// toward the data Memory block.
//
// Handshake semantics (request channel):
//   A request is transferred on a rising clock edge where req_valid and
//   req_ready are both high. req_ready depends only on the unit's state and
//   reset, never on req_valid. A requester may assert req_valid at any time.
//   Requests presented while req_ready is low are ignored, not queued.
//   The response is a one-cycle resp_valid pulse with no back-pressure:
//   the consumer must take resp_rdata/resp_err in that cycle.
//
// Modports:
//   slave  - the load/store unit (consumes requests, drives Memory ports).
//   master - the surrounding environment (execute stage plus Memory).
//
// Signals:
//   req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata : request
//   resp_valid/resp_rdata/resp_err                              : response
//   memory_write/memory_size/memory_addr/memory_data_in         : to Memory
//   memory_data_out                                             : from Memory
// ----------------------------------------------------------------------------
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        memory_write;
    logic [1:0]  memory_size;
    logic [31:0] memory_addr;
    logic [31:0] memory_data_in;
    logic [31:0] memory_data_out;

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_funct3,
        input  req_addr,
        input  req_wdata,
        input  memory_data_out,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err,
        output memory_write,
        output memory_size,
        output memory_addr,
        output memory_data_in
    );

    modport master (
        output req_valid,
        output req_write,
        output req_funct3,
        output req_addr,
        output req_wdata,
        output memory_data_out,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err,
        input  memory_write,
        input  memory_size,
        input  memory_addr,
        input  memory_data_in
    );
endinterface

// File: rtl/lsu_ctrl.sv
// ----------------------------------------------------------------------------
// lsu_ctrl
//
// Load/store unit in front of the data Memory block. Takes one load or store
// at a time, drives Memory with naturally aligned transfers only (misaligned
// halfword/word accesses become sequential byte beats), and returns a sign-
// or zero-extended 32-bit load result.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous, active-low reset
//   bus          slave modport of lsu_ctrl_if (request, response, Memory)
//   dbg_state_o  out  current FSM state (0 IDLE, 1 ISSUE, 2 CAPTURE, 3 RESP)
//
// All memory_* outputs come straight from registers, so there is no
// combinational path from req_* to memory_*.
// ----------------------------------------------------------------------------
module lsu_ctrl (
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.slave  bus,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_e;

    // One Memory transfer: what goes onto memory_size/addr/data_in.
    typedef struct packed {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    // Loads accept 0,1,2,4,5; stores accept 0,1,2.
    function automatic logic funct3_legal(input logic write, input logic [2:0] funct3);
        logic ok;
        if (write) begin
            ok = (funct3 <= 3'd2);
        end else begin
            ok = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
        end
        return ok;
    endfunction

    // funct3[1:0] is the native access size for every legal encoding.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [31:0] addr);
        return ((funct3[1:0] == 2'd1) && addr[0]) ||
               ((funct3[1:0] == 2'd2) && (addr[1:0] != 2'b00));
    endfunction

    // Byte beats walk the address upward (wrapping mod 2^32) and carry one
    // store byte right-aligned; aligned transfers pass everything through.
    function automatic beat_t make_beat(input logic        split,
                                        input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input logic [31:0] wdata,
                                        input logic [1:0]  beat);
        beat_t b;
        if (split) begin
            b.size = 2'd0;
            b.addr = addr + {30'd0, beat};
            b.data = {24'd0, wdata[{beat, 3'b000} +: 8]};
        end else begin
            b.size = size;
            b.addr = addr;
            b.data = wdata;
        end
        return b;
    endfunction

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic        split_q, split_d;
    logic        err_q, err_d;
    logic [1:0]  beat_q, beat_d;
    logic [1:0]  last_q, last_d;

    logic        mem_write_q, mem_write_d;
    logic [1:0]  mem_size_q, mem_size_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_q, mem_data_d;

    logic        ready;
    logic        accept;
    logic        req_legal;
    logic        req_split;
    logic [1:0]  beat_inc;
    logic        at_last;
    beat_t       first_beat;
    beat_t       next_beat;

    // Reset is synchronous, but req_ready must already read low while rst is
    // held, before any edge has cleaned up the state register.
    assign ready     = rst && (state_q == S_IDLE);
    assign accept    = bus.req_valid && ready;
    assign req_legal = funct3_legal(bus.req_write, bus.req_funct3);
    assign req_split = is_misaligned(bus.req_funct3, bus.req_addr);
    assign beat_inc  = beat_q + 2'd1;
    assign at_last   = (beat_q == last_q);

    // Beat 0 is built from the request itself so it is registered onto the
    // Memory ports at the accepting edge and visible during the first ISSUE.
    assign first_beat = make_beat(req_split, bus.req_funct3[1:0], bus.req_addr,
                                  bus.req_wdata, 2'd0);
    assign next_beat  = make_beat(split_q, funct3_q[1:0], addr_q, wdata_q, beat_inc);

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        split_d     = split_q;
        err_d       = err_q;
        beat_d      = beat_q;
        last_d      = last_q;
        mem_write_d = 1'b0;
        mem_size_d  = mem_size_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    write_d  = bus.req_write;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    buf_d    = 32'd0;
                    beat_d   = 2'd0;
                    if (!req_legal) begin
                        err_d   = 1'b1;
                        split_d = 1'b0;
                        last_d  = 2'd0;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        split_d = req_split;
                        // Split halfword = 2 byte beats, split word = 4.
                        if (!req_split) begin
                            last_d = 2'd0;
                        end else if (bus.req_funct3[1:0] == 2'd1) begin
                            last_d = 2'd1;
                        end else begin
                            last_d = 2'd3;
                        end
                        mem_write_d = bus.req_write;
                        mem_size_d  = first_beat.size;
                        mem_addr_d  = first_beat.addr;
                        mem_data_d  = first_beat.data;
                        state_d     = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                if (write_q) begin
                    if (at_last) begin
                        state_d = S_RESP;
                    end else begin
                        beat_d      = beat_inc;
                        mem_write_d = 1'b1;
                        mem_size_d  = next_beat.size;
                        mem_addr_d  = next_beat.addr;
                        mem_data_d  = next_beat.data;
                    end
                end else begin
                    state_d = S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                // Read data belongs to the address presented in ISSUE,
                // which is still held on memory_addr.
                if (split_q) begin
                    buf_d[{beat_q, 3'b000} +: 8] = bus.memory_data_out[7:0];
                end else begin
                    buf_d = bus.memory_data_out;
                end
                if (at_last) begin
                    state_d = S_RESP;
                end else begin
                    beat_d     = beat_inc;
                    mem_size_d = next_beat.size;
                    mem_addr_d = next_beat.addr;
                    mem_data_d = next_beat.data;
                    state_d    = S_ISSUE;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            split_q     <= 1'b0;
            err_q       <= 1'b0;
            beat_q      <= 2'd0;
            last_q      <= 2'd0;
            mem_write_q <= 1'b0;
            mem_size_q  <= 2'd0;
            mem_addr_q  <= 32'd0;
            mem_data_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            split_q     <= split_d;
            err_q       <= err_d;
            beat_q      <= beat_d;
            last_q      <= last_d;
            mem_write_q <= mem_write_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

    // Response: stores and errors return zero data.
    always_comb begin
        bus.resp_rdata = 32'd0;
        if ((state_q == S_RESP) && !write_q && !err_q) begin
            case (funct3_q)
                3'd0:    bus.resp_rdata = {{24{buf_q[7]}}, buf_q[7:0]};
                3'd1:    bus.resp_rdata = {{16{buf_q[15]}}, buf_q[15:0]};
                3'd2:    bus.resp_rdata = buf_q;
                3'd4:    bus.resp_rdata = {24'd0, buf_q[7:0]};
                3'd5:    bus.resp_rdata = {16'd0, buf_q[15:0]};
                default: bus.resp_rdata = 32'd0;
            endcase
        end
    end

    assign bus.req_ready      = ready;
    assign bus.resp_valid     = (state_q == S_RESP);
    assign bus.resp_err       = (state_q == S_RESP) && err_q;
    assign bus.memory_write   = mem_write_q;
    assign bus.memory_size    = mem_size_q;
    assign bus.memory_addr    = mem_addr_q;
    assign bus.memory_data_in = mem_data_q;
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
`timescale 1ns/1ps
module tb_lsu_ctrl;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    lsu_ctrl_if bus();

    lsu_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- counters / checker ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- Memory block model (serves the DUT) ----------------
    logic [7:0] bus_mem [logic [31:0]];

    function automatic logic [7:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : 8'h00;
    endfunction

    function automatic int size_bytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    always @(posedge clk) begin
        logic [31:0] r;
        int          n;
        n = size_bytes(bus.memory_size);
        if (bus.memory_write) begin
            for (int i = 0; i < n; i++)
                bus_mem[bus.memory_addr + 32'(i)] = bus.memory_data_in[8*i +: 8];
        end
        r = 32'd0;
        for (int i = 0; i < n; i++)
            r[8*i +: 8] = bus_rd(bus.memory_addr + 32'(i));
        bus.memory_data_out <= r;
    end

    // ---------------- reference model + scoreboard ----------------
    // Expected store beats on the Memory port: {size, addr, data_in}.
    logic [65:0] exp_q[$];
    logic [7:0]  ref_mem [logic [31:0]];

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic model_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] rd,
                             output logic err, output int lat);
        int          nb;
        int          beats;
        bit          split;
        logic [31:0] v;
        logic [1:0]  sz;
        rd  = 32'd0;
        err = w ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (err) begin
            lat = 1;
            return;
        end
        case (f3)
            3'd0, 3'd4: nb = 1;
            3'd1, 3'd5: nb = 2;
            default:    nb = 4;
        endcase
        sz    = (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
        split = (a % nb) != 0;
        beats = split ? nb : 1;
        lat   = w ? beats + 1 : 2 * beats + 1;
        if (w) begin
            for (int i = 0; i < nb; i++) begin
                ref_mem[a + 32'(i)] = wd[8*i +: 8];
                if (split) exp_q.push_back({2'd0, a + 32'(i), 24'd0, wd[8*i +: 8]});
            end
            if (!split) exp_q.push_back({sz, a, wd});
        end else begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_rd(a + 32'(i));
            case (f3)
                3'd0:    rd = {{24{v[7]}}, v[7:0]};
                3'd1:    rd = {{16{v[15]}}, v[15:0]};
                3'd4:    rd = {24'd0, v[7:0]};
                3'd5:    rd = {16'd0, v[15:0]};
                default: rd = v;
            endcase
        end
    endtask

    // Every cycle with memory_write high must match the next expected beat.
    always @(negedge clk) begin
        logic [65:0] e;
        if (bus.memory_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL store_beat: unexpected write size %0d addr %h data %h",
                         bus.memory_size, bus.memory_addr, bus.memory_data_in);
            end else begin
                e = exp_q.pop_front();
                check("store_beat", {bus.memory_size, bus.memory_addr, bus.memory_data_in}, e);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input string name, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int k;
        bit got;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.req_ready) begin
            check({name, "_accept_timeout"}, 66'(bus.req_ready), 66'd1);
            bus.req_valid = 1'b0;
            exp_q.delete();
            return;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        k   = 0;
        got = 0;
        while (k < 20 && !got) begin
            @(negedge clk);
            k++;
            if (bus.resp_valid) got = 1;
        end
        check({name, "_latency"}, 66'(got ? k : 99), 66'(exp_lat));
        check({name, "_rdata"}, 66'(bus.resp_rdata), 66'(exp_rd));
        check({name, "_err"}, 66'(bus.resp_err), 66'(exp_err));
        @(negedge clk);
        check({name, "_resp_one_cycle"}, 66'(bus.resp_valid), 66'd0);
        check({name, "_ready_again"}, 66'(bus.req_ready), 66'd1);
        check({name, "_beats_left"}, 66'(exp_q.size()), 66'd0);
        exp_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    initial begin
        logic [31:0] m_rd;
        logic        m_err;
        int          m_lat;
        int          k;
        bit          got;

        vecs[0]  = '{1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2};
        vecs[1]  = '{1'b0, 3'd2, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 3};
        vecs[2]  = '{1'b0, 3'd0, 32'h0000_0010, 32'h0,         32'hFFFF_FFEF, 1'b0, 3};
        vecs[3]  = '{1'b0, 3'd5, 32'h0000_0012, 32'h0,         32'h0000_DEAD, 1'b0, 3};
        vecs[4]  = '{1'b1, 3'd0, 32'h0000_0021, 32'h0000_0080, 32'h0000_0000, 1'b0, 2};
        vecs[5]  = '{1'b0, 3'd0, 32'h0000_0021, 32'h0,         32'hFFFF_FF80, 1'b0, 3};
        vecs[6]  = '{1'b0, 3'd4, 32'h0000_0021, 32'h0,         32'h0000_0080, 1'b0, 3};
        vecs[7]  = '{1'b1, 3'd2, 32'h0000_0031, 32'h1122_3344, 32'h0000_0000, 1'b0, 5};
        vecs[8]  = '{1'b0, 3'd2, 32'h0000_0031, 32'h0,         32'h1122_3344, 1'b0, 9};
        vecs[9]  = '{1'b0, 3'd1, 32'h0000_0033, 32'h0,         32'h0000_1122, 1'b0, 5};
        vecs[10] = '{1'b0, 3'd5, 32'h0000_0033, 32'h0,         32'h0000_1122, 1'b0, 5};
        vecs[11] = '{1'b0, 3'd3, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1, 1};
        vecs[12] = '{1'b1, 3'd5, 32'h0000_0050, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1};
        vecs[13] = '{1'b1, 3'd1, 32'h0000_0041, 32'h1234_ABCD, 32'h0000_0000, 1'b0, 3};
        vecs[14] = '{1'b0, 3'd1, 32'h0000_0041, 32'h0,         32'hFFFF_ABCD, 1'b0, 5};
        vecs[15] = '{1'b0, 3'd1, 32'h0000_0040, 32'h0,         32'hFFFF_CD00, 1'b0, 3};
        vecs[16] = '{1'b0, 3'd2, 32'h0000_0012, 32'h0,         32'h0000_DEAD, 1'b0, 9};
        vecs[17] = '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0000_5AA5, 32'h0000_0000, 1'b0, 3};
        vecs[18] = '{1'b1, 3'd2, 32'h0000_0022, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 5};
        vecs[19] = '{1'b0, 3'd5, 32'h0000_0023, 32'h0,         32'h0000_FEF0, 1'b0, 5};
        vecs[20] = '{1'b0, 3'd0, 32'h0000_0025, 32'h0,         32'hFFFF_FFCA, 1'b0, 3};
        vecs[21] = '{1'b1, 3'd0, 32'h0000_0026, 32'h1234_5678, 32'h0000_0000, 1'b0, 2};
        vecs[22] = '{1'b0, 3'd2, 32'h0000_0024, 32'h0,         32'h0078_CAFE, 1'b0, 3};

        // ---------- reset ----------
        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_req_ready",  66'(bus.req_ready), 66'd0);
        check("rst_mem_write",  66'(bus.memory_write), 66'd0);
        check("rst_mem_addr",   66'(bus.memory_addr), 66'd0);
        check("rst_mem_size",   66'(bus.memory_size), 66'd0);
        check("rst_mem_data",   66'(bus.memory_data_in), 66'd0);
        check("rst_resp_valid", 66'(bus.resp_valid), 66'd0);
        check("rst_resp_rdata", 66'(bus.resp_rdata), 66'd0);
        check("rst_resp_err",   66'(bus.resp_err), 66'd0);
        check("rst_state",      66'(dbg_state), 66'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_release_ready", 66'(bus.req_ready), 66'd1);

        // ---------- table-driven directed vectors ----------
        for (int i = 0; i < NV; i++) begin
            model_req(vecs[i].write, vecs[i].funct3, vecs[i].addr, vecs[i].wdata,
                      m_rd, m_err, m_lat);
            do_req($sformatf("vec%0d", i), vecs[i].write, vecs[i].funct3, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);
        end

        // ---------- wrap + held req_valid ----------
        model_req(1'b0, 3'd1, 32'hFFFF_FFFF, 32'd0, m_rd, m_err, m_lat);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd1;
        bus.req_addr   = 32'hFFFF_FFFF;
        bus.req_wdata  = 32'd0;
        check("hold_ready_first", 66'(bus.req_ready), 66'd1);
        @(posedge clk);
        k   = 0;
        got = 0;
        while (k < 20 && !got) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check("wrap_beat0_addr", 66'(bus.memory_addr), 66'hFFFF_FFFF);
                check("wrap_beat0_size", 66'(bus.memory_size), 66'd0);
            end
            if (k == 3) begin
                check("wrap_beat1_addr", 66'(bus.memory_addr), 66'd0);
                check("wrap_beat1_size", 66'(bus.memory_size), 66'd0);
            end
            check("hold_ready_low", 66'(bus.req_ready), 66'd0);
            if (bus.resp_valid) got = 1;
        end
        check("wrap_latency", 66'(got ? k : 99), 66'(m_lat));
        check("wrap_rdata", 66'(bus.resp_rdata), 66'(m_rd));
        @(negedge clk);
        check("hold_ready_back", 66'(bus.req_ready), 66'd1);
        bus.req_valid = 1'b0;

        // ---------- reset during second CAPTURE of a split LW ----------
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h0000_0031;
        check("abort_ready", 66'(bus.req_ready), 66'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready_in_rst", 66'(bus.req_ready), 66'd0);
        @(negedge clk);
        check("abort_mem_write",  66'(bus.memory_write), 66'd0);
        check("abort_mem_addr",   66'(bus.memory_addr), 66'd0);
        check("abort_mem_size",   66'(bus.memory_size), 66'd0);
        check("abort_mem_data",   66'(bus.memory_data_in), 66'd0);
        check("abort_resp_valid", 66'(bus.resp_valid), 66'd0);
        check("abort_resp_rdata", 66'(bus.resp_rdata), 66'd0);
        check("abort_resp_err",   66'(bus.resp_err), 66'd0);
        check("abort_state",      66'(dbg_state), 66'd0);
        @(negedge clk);
        check("abort_no_resp", 66'(bus.resp_valid), 66'd0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_release_ready", 66'(bus.req_ready), 66'd1);
        check("abort_after_no_resp", 66'(bus.resp_valid), 66'd0);
        model_req(1'b0, 3'd2, 32'h0000_0010, 32'd0, m_rd, m_err, m_lat);
        do_req("after_abort_lw", 1'b0, 3'd2, 32'h0000_0010, 32'd0, m_rd, m_err, m_lat);

        // ---------- randomized traffic against the reference model ----------
        for (int n = 0; n < 150; n++) begin
            logic        w;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] wd;
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            else                           a = 32'h0000_0200 + 32'($urandom_range(0, 31));
            wd = $urandom;
            model_req(w, f3, a, wd, m_rd, m_err, m_lat);
            do_req($sformatf("rnd%0d", n), w, f3, a, wd, m_rd, m_err, m_lat);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
